// File: rtl/data_memory_pkg.sv
// Shared constants and store byte-lane helpers for the MEM-stage data RAM.
// Lane helpers assume 8-bit lanes inside one RV32 data word.
package data_memory_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_LANES  = DATA_WIDTH / 8;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  // Byte lanes touched by a store of the given size at the given byte offset.
  function automatic logic [NUM_LANES-1:0] byte_enable(input logic [2:0] funct3,
                                                       input logic [1:0] offset);
    logic [NUM_LANES-1:0] be;
    be = '0;
    case (funct3)
      FUNCT3_SB: be = NUM_LANES'(1) << offset;
      FUNCT3_SH: be = offset[1] ? 4'b1100 : 4'b0011;
      FUNCT3_SW: be = '1;
      default:   be = '0;
    endcase
    return be;
  endfunction

  // Replicates right-aligned store data across every lane it could land in.
  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [2:0] funct3,
                                                      input logic [DATA_WIDTH-1:0] data);
    logic [DATA_WIDTH-1:0] word;
    case (funct3)
      FUNCT3_SB: word = {4{data[7:0]}};
      FUNCT3_SH: word = {2{data[15:0]}};
      default:   word = data;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM with byte-masked stores, registered full-word reads
// and forwarding of a concurrent WB-stage store to the same word.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_LSB  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_MemWrite_en,
  input  logic                  MEM_MemRead_en,
  input  logic                  WB_MemWrite_en,
  input  logic [2:0]            MEM_funct3_i,
  input  logic [DATA_WIDTH-1:0] MEM_addr_i,
  input  logic [DATA_WIDTH-1:0] WB_addr_i,
  input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
  input  logic [DATA_WIDTH-1:0] WB_wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [IDX_W-1:0]      mem_idx;
  logic [IDX_W-1:0]      wb_idx;
  logic [NUM_LANES-1:0]  wr_be;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  fwd;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  unused_addr_bits;

  assign mem_idx = MEM_addr_i[ADDR_LSB +: IDX_W];
  assign wb_idx  = WB_addr_i[ADDR_LSB +: IDX_W];

  // Upper address bits wrap; WB byte offset is irrelevant for word matching.
  assign unused_addr_bits = ^{MEM_addr_i[DATA_WIDTH-1:ADDR_LSB+IDX_W],
                              WB_addr_i[DATA_WIDTH-1:ADDR_LSB+IDX_W],
                              WB_addr_i[ADDR_LSB-1:0]};

  always_comb begin
    wr_be   = MEM_MemWrite_en ? byte_enable(MEM_funct3_i, MEM_addr_i[1:0]) : '0;
    wr_word = lane_data(MEM_funct3_i, MEM_wr_data_i);
  end

  // Per-lane write enables keep the array block-RAM mappable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_be[i]) begin
        mem_q[mem_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
  end

  always_comb begin
    fwd       = WB_MemWrite_en && (wb_idx == mem_idx);
    rd_data_d = rd_data_q;
    if (MEM_MemRead_en) begin
      rd_data_d = fwd ? WB_wr_data_i : mem_q[mem_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: expected read words are queued when a
// read is issued and compared when the registered output appears.
module tb_data_memory;
  import data_memory_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  MEM_MemWrite_en;
  logic                  MEM_MemRead_en;
  logic                  WB_MemWrite_en;
  logic [2:0]            MEM_funct3_i;
  logic [DATA_WIDTH-1:0] MEM_addr_i;
  logic [DATA_WIDTH-1:0] WB_addr_i;
  logic [DATA_WIDTH-1:0] MEM_wr_data_i;
  logic [DATA_WIDTH-1:0] WB_wr_data_i;
  logic [DATA_WIDTH-1:0] rd_data_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];
  logic [31:0] got;
  logic [31:0] exp_w;

  data_memory #(.MEM_DEPTH(1024), .ADDR_LSB(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_MemWrite_en(MEM_MemWrite_en),
    .MEM_MemRead_en (MEM_MemRead_en),
    .WB_MemWrite_en (WB_MemWrite_en),
    .MEM_funct3_i   (MEM_funct3_i),
    .MEM_addr_i     (MEM_addr_i),
    .WB_addr_i      (WB_addr_i),
    .MEM_wr_data_i  (MEM_wr_data_i),
    .WB_wr_data_i   (WB_wr_data_i),
    .rd_data_o      (rd_data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic drive_idle();
    @(negedge clk);
    MEM_MemWrite_en = 1'b0;
    MEM_MemRead_en  = 1'b0;
    WB_MemWrite_en  = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
    @(negedge clk);
    MEM_MemWrite_en = 1'b1;
    MEM_MemRead_en  = 1'b0;
    WB_MemWrite_en  = 1'b0;
    MEM_funct3_i    = f3;
    MEM_addr_i      = addr;
    MEM_wr_data_i   = data;
    $display("write addr=%h funct3=%b data=%h", addr, f3, data);
    @(posedge clk);
  endtask

  // Leaves the bench 1 time unit after the capturing edge.
  task automatic issue_read(input logic [31:0] addr, input logic wb_en, input logic [31:0] wb_addr,
                            input logic [31:0] wb_data, input logic [31:0] expected);
    @(negedge clk);
    MEM_MemWrite_en = 1'b0;
    MEM_MemRead_en  = 1'b1;
    WB_MemWrite_en  = wb_en;
    MEM_funct3_i    = FUNCT3_SW;
    MEM_addr_i      = addr;
    WB_addr_i       = wb_addr;
    WB_wr_data_i    = wb_data;
    sb_q.push_back(expected);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    MEM_MemWrite_en = 1'b0;
    MEM_MemRead_en  = 1'b0;
    WB_MemWrite_en  = 1'b0;
    MEM_funct3_i    = FUNCT3_SW;
    MEM_addr_i      = '0;
    WB_addr_i       = '0;
    MEM_wr_data_i   = '0;
    WB_wr_data_i    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_value got=%h exp=%h", rd_data_o, 32'h0);
    end else $display("reset rd_data_o=%h", rd_data_o);
    rst = 1'b0;
  endtask

  task automatic test_sw();
    do_write(32'h100, FUNCT3_SW, 32'hDEADBEEF);
    issue_read(32'h100, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL sw_read got=%h exp=%h", got, exp_w);
    end else $display("read @100 got=%h", got);
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_data_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_hold got=%h exp=%h", rd_data_o, 32'hDEADBEEF);
    end else $display("hold got=%h", rd_data_o);
  endtask

  task automatic test_sh();
    do_write(32'h200, FUNCT3_SW, 32'hAAAAAAAA);
    do_write(32'h200, FUNCT3_SH, 32'h1234CAFE);
    do_write(32'h202, FUNCT3_SH, 32'h5678BEEF);
    issue_read(32'h200, 1'b0, 32'h0, 32'h0, 32'hBEEFCAFE);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL sh_merge got=%h exp=%h", got, exp_w);
    end else $display("read @200 got=%h", got);
  endtask

  task automatic test_sb();
    do_write(32'h300, FUNCT3_SW, 32'hFFFFFFFF);
    do_write(32'h300, FUNCT3_SB, 32'hxxxxxx11);
    do_write(32'h301, FUNCT3_SB, 32'hxxxxxx22);
    do_write(32'h302, FUNCT3_SB, 32'hxxxxxx33);
    do_write(32'h303, FUNCT3_SB, 32'hxxxxxx44);
    issue_read(32'h300, 1'b0, 32'h0, 32'h0, 32'h44332211);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL sb_merge got=%h exp=%h", got, exp_w);
    end else $display("read @300 got=%h", got);
  endtask

  task automatic test_forward();
    do_write(32'h400, FUNCT3_SW, 32'h11111111);
    issue_read(32'h400, 1'b1, 32'h400, 32'hFFFFFFFF, 32'hFFFFFFFF);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL fwd_hit got=%h exp=%h", got, exp_w);
    end else $display("read @400 fwd hit got=%h", got);
    issue_read(32'h400, 1'b1, 32'h404, 32'hFFFFFFFF, 32'h11111111);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL fwd_miss got=%h exp=%h", got, exp_w);
    end else $display("read @400 fwd miss got=%h", got);
    issue_read(32'h400, 1'b0, 32'h400, 32'hFFFFFFFF, 32'h11111111);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL fwd_disabled got=%h exp=%h", got, exp_w);
    end else $display("read @400 wb idle got=%h", got);
  endtask

  task automatic test_async_reset();
    issue_read(32'h100, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL pre_reset_read got=%h exp=%h", got, exp_w);
    end else $display("read @100 got=%h", got);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rd_data_o !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", rd_data_o, 32'h0);
    end else $display("async reset rd_data_o=%h", rd_data_o);
    @(negedge clk);
    rst = 1'b0;
    issue_read(32'h100, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL retained_after_reset got=%h exp=%h", got, exp_w);
    end else $display("read @100 after reset got=%h", got);
  endtask

  task automatic test_bad_funct3_and_alias();
    do_write(32'h100, 3'b011, 32'h00000000);
    issue_read(32'h100, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL bad_funct3 got=%h exp=%h", got, exp_w);
    end else $display("read @100 after funct3=011 got=%h", got);
    issue_read(32'h1100, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL alias_read got=%h exp=%h", got, exp_w);
    end else $display("read @1100 got=%h", got);
    do_write(32'h2500, FUNCT3_SW, 32'h0BADF00D);
    issue_read(32'h500, 1'b0, 32'h0, 32'h0, 32'h0BADF00D);
    got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
    if (got !== exp_w) begin
      failures++;
      $display("FAIL alias_write got=%h exp=%h", got, exp_w);
    end else $display("read @500 got=%h", got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] words [4];
    addrs = '{32'h100, 32'h200, 32'h300, 32'h400};
    words = '{32'hDEADBEEF, 32'hBEEFCAFE, 32'h44332211, 32'h11111111};
    for (int i = 0; i < 4; i++) begin
      issue_read(addrs[i], 1'b0, 32'h0, 32'h0, words[i]);
      got = rd_data_o; exp_w = sb_q.pop_front(); checks++;
      if (got !== exp_w) begin
        failures++;
        $display("FAIL b2b_read%0d got=%h exp=%h", i, got, exp_w);
      end else $display("b2b read @%h got=%h", addrs[i], got);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sh();
    test_sb();
    test_forward();
    test_async_reset();
    test_bad_funct3_and_alias();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
